// File: rtl/audio_pkg.sv
// Shared audio types for the codec-side serializer: sample/frame widths,
// sample type and the serializer state encoding.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } ser_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input sample_t l, input sample_t r);
    return {l, r};
  endfunction

endpackage

// File: rtl/dac_serializer.sv
// I2S-style DAC serializer: one-frame holding register, LRCK edge detect, channel FSM and shifter.
// Build option DAC_SER_UNDERRUN_REPEAT_EN: on underrun replay the last transmitted frame instead of silence.
//
// state     | meaning
// WAIT_SYNC | after reset, no LRCK rising edge seen yet; DACDAT held low
// LEFT      | shifting the left sample (upper frame half), then idle-low
// RIGHT     | shifting the right sample (lower frame half), then idle-low
module dac_serializer
  import audio_pkg::*;
(
  input  logic                       BCLK,
  input  logic                       RST_N,
  input  logic                       DACLRCK,
  output logic                       DACDAT,
  input  logic signed [SAMPLE_W-1:0] leftSample,
  input  logic signed [SAMPLE_W-1:0] rightSample,
  input  logic                       sampleValid,
  output logic                       sampleReady,
  output logic                       underrun
);

  ser_state_e         state_q, state_d;
  logic               lrck_q;
  logic               hold_full_q, hold_full_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]         bits_left_q, bits_left_d;
  logic               dacdat_q, dacdat_d;
  logic               ready_q, ready_d;
  logic               underrun_q, underrun_d;

  logic               lrck_rise, lrck_fall, frame_start, accept;
  logic [FRAME_W-1:0] under_frame, start_frame;

  assign lrck_rise   = ~lrck_q & DACLRCK;
  assign lrck_fall   = lrck_q & ~DACLRCK;
  assign frame_start = lrck_rise & (state_q != LEFT);
  assign accept      = sampleValid & ready_q;
  assign start_frame = hold_full_q ? hold_q : under_frame;

`ifdef DAC_SER_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0] last_q, last_d;

  assign under_frame = last_q;

  always_comb begin
    last_d = last_q;
    if (frame_start && hold_full_q) last_d = hold_q;
  end

  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  assign under_frame = '0;
`endif

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    dacdat_d    = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      WAIT_SYNC, RIGHT: begin
        if (lrck_rise) begin
          state_d     = LEFT;
          // Left MSB goes out now; the rest of the left half shifts from bit 31.
          dacdat_d    = start_frame[FRAME_W-1];
          shift_d     = {start_frame[FRAME_W-2:SAMPLE_W], 1'b0, start_frame[SAMPLE_W-1:0]};
          bits_left_d = 4'd15;
          if (hold_full_q) hold_full_d = 1'b0;
          else             underrun_d  = 1'b1;
        end else if (state_q == RIGHT && bits_left_q != 4'd0) begin
          dacdat_d              = shift_q[SAMPLE_W-1];
          shift_d[SAMPLE_W-1:0] = {shift_q[SAMPLE_W-2:0], 1'b0};
          bits_left_d           = bits_left_q - 4'd1;
        end
      end
      LEFT: begin
        if (lrck_fall) begin
          // Right channel restarts regardless of how much of the left was sent.
          state_d               = RIGHT;
          dacdat_d              = shift_q[SAMPLE_W-1];
          shift_d[SAMPLE_W-1:0] = {shift_q[SAMPLE_W-2:0], 1'b0};
          bits_left_d           = 4'd15;
        end else if (bits_left_q != 4'd0) begin
          dacdat_d                     = shift_q[FRAME_W-1];
          shift_d[FRAME_W-1:SAMPLE_W]  = {shift_q[FRAME_W-2:SAMPLE_W], 1'b0};
          bits_left_d                  = bits_left_q - 4'd1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    // An acceptance coinciding with an empty-register frame start lands in holding.
    if (accept) begin
      hold_d      = pack_frame(leftSample, rightSample);
      hold_full_d = 1'b1;
    end

    ready_d = ~hold_full_d;
  end

  always_ff @(posedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= WAIT_SYNC;
      lrck_q      <= 1'b1;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bits_left_q <= 4'd0;
      dacdat_q    <= 1'b0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_q      <= DACLRCK;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      dacdat_q    <= dacdat_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
    end
  end

  assign DACDAT      = dacdat_q;
  assign sampleReady = ready_q;
  assign underrun    = underrun_q;

endmodule
